// File: rtl/perceptron_epoch_sequencer_pkg.sv
// Shared types and default widths for the perceptron epoch sequencer
// and the perceptron core test environment.
package perceptron_epoch_sequencer_pkg;

  localparam int ADDR_W  = 6;
  localparam int DATA_W  = 16;
  localparam int EPOCH_W = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_CAPTURE   = 3'd2,
    S_ISSUE     = 3'd3,
    S_WAIT      = 3'd4,
    S_NEXT      = 3'd5,
    S_EPOCH_END = 3'd6,
    S_DONE      = 3'd7
  } state_e;

  function automatic logic abortable(state_e s);
    return !(s == S_IDLE || s == S_DONE);
  endfunction

endpackage

// File: rtl/perceptron_epoch_sequencer_if.sv
// Sample-memory read port and core sample/handshake bundle.
// The sequencer is master; memory and core sit on the slave side.
interface perceptron_epoch_sequencer_if #(
  parameter int ADDR_W = perceptron_epoch_sequencer_pkg::ADDR_W,
  parameter int DATA_W = perceptron_epoch_sequencer_pkg::DATA_W
);

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_x1;
  logic [DATA_W-1:0] mem_x2;
  logic [DATA_W-1:0] mem_t;
  logic [DATA_W-1:0] core_x1;
  logic [DATA_W-1:0] core_x2;
  logic [DATA_W-1:0] core_t;
  logic              core_go;
  logic              core_done;
  logic              core_error;

  modport master (
    output mem_addr, mem_rd,
    output core_x1, core_x2, core_t, core_go,
    input  mem_x1, mem_x2, mem_t,
    input  core_done, core_error
  );

  modport slave (
    input  mem_addr, mem_rd,
    input  core_x1, core_x2, core_t, core_go,
    output mem_x1, mem_x2, mem_t,
    output core_done, core_error
  );

endinterface

// File: rtl/perceptron_epoch_sequencer_seq_watchdog.sv
// Cycle watchdog: cleared before each core request, counts while enabled
// and raises tc on the LIMIT-th counted cycle.
module seq_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/perceptron_epoch_sequencer.sv
// Epoch sequencer: streams samples to the perceptron core, counts
// per-epoch errors and stops on convergence, limit, timeout or abort.
module perceptron_epoch_sequencer #(
  parameter int ADDR_W  = perceptron_epoch_sequencer_pkg::ADDR_W,
  parameter int DATA_W  = perceptron_epoch_sequencer_pkg::DATA_W,
  parameter int EPOCH_W = perceptron_epoch_sequencer_pkg::EPOCH_W,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [ADDR_W-1:0]  num_samples,
  input  logic [EPOCH_W-1:0] max_epochs,
  perceptron_epoch_sequencer_if.master bus,
  output logic               busy,
  output logic               done,
  output logic               converged,
  output logic               timed_out,
  output logic               aborted,
  output logic [EPOCH_W-1:0] epoch_count,
  output logic [ADDR_W-1:0]  err_count
);

  import perceptron_epoch_sequencer_pkg::*;

  state_e             state;
  logic [ADDR_W-1:0]  num_q;
  logic [EPOCH_W-1:0] max_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               rd_q;
  logic               go_q;
  logic [DATA_W-1:0]  x1_q;
  logic [DATA_W-1:0]  x2_q;
  logic [DATA_W-1:0]  t_q;
  logic               wd_tc;
  logic               abort_hit;

  seq_watchdog #(
    .LIMIT (TIMEOUT)
  ) u_wd (
    .clk (clk),
    .rst (rst),
    .clr (state == S_ISSUE),
    .en  (state == S_WAIT),
    .tc  (wd_tc)
  );

  assign abort_hit = abort && abortable(state);

  assign bus.mem_addr = addr_q;
  assign bus.mem_rd   = rd_q;
  assign bus.core_go  = go_q;
  assign bus.core_x1  = x1_q;
  assign bus.core_x2  = x2_q;
  assign bus.core_t   = t_q;

  // Pulses are set on the transition into their state so they are
  // registered and line up exactly with FETCH, ISSUE and DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      num_q       <= '0;
      max_q       <= '0;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      go_q        <= 1'b0;
      x1_q        <= '0;
      x2_q        <= '0;
      t_q         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      converged   <= 1'b0;
      timed_out   <= 1'b0;
      aborted     <= 1'b0;
      epoch_count <= '0;
      err_count   <= '0;
    end else begin
      rd_q <= 1'b0;
      go_q <= 1'b0;
      done <= 1'b0;
      if (abort_hit) begin
        aborted <= 1'b1;
        done    <= 1'b1;
        state   <= S_DONE;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              num_q       <= num_samples;
              max_q       <= max_epochs;
              addr_q      <= '0;
              epoch_count <= '0;
              err_count   <= '0;
              converged   <= 1'b0;
              timed_out   <= 1'b0;
              aborted     <= 1'b0;
              busy        <= 1'b1;
              if (num_samples == '0 || max_epochs == '0) begin
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                rd_q  <= 1'b1;
                state <= S_FETCH;
              end
            end
          end
          S_FETCH: state <= S_CAPTURE;
          S_CAPTURE: begin
            x1_q  <= bus.mem_x1;
            x2_q  <= bus.mem_x2;
            t_q   <= bus.mem_t;
            go_q  <= 1'b1;
            state <= S_ISSUE;
          end
          S_ISSUE: state <= S_WAIT;
          S_WAIT: begin
            if (bus.core_done) begin
              if (bus.core_error && err_count != '1)
                err_count <= err_count + 1'b1;
              state <= S_NEXT;
            end else if (wd_tc) begin
              timed_out <= 1'b1;
              done      <= 1'b1;
              state     <= S_DONE;
            end
          end
          S_NEXT: begin
            if (addr_q == num_q - 1'b1) begin
              state <= S_EPOCH_END;
            end else begin
              addr_q <= addr_q + 1'b1;
              rd_q   <= 1'b1;
              state  <= S_FETCH;
            end
          end
          S_EPOCH_END: begin
            epoch_count <= epoch_count + 1'b1;
            if (err_count == '0) begin
              converged <= 1'b1;
              done      <= 1'b1;
              state     <= S_DONE;
            end else if ((epoch_count + 1'b1) == max_q) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              addr_q    <= '0;
              err_count <= '0;
              rd_q      <= 1'b1;
              state     <= S_FETCH;
            end
          end
          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
